// File: rtl/sprite_jump_ctl_if.sv
// Button inputs and sprite position/status outputs of the jump controller.
// The master drives the buttons and frame tick; the slave is the controller.
interface sprite_jump_ctl_if;
  logic        v_tick;
  logic        btn_jump;
  logic        btn_left;
  logic        btn_right;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [2:0]  state_out;
  logic        airborne;
  logic        landed;

  modport master (
    output v_tick, btn_jump, btn_left, btn_right,
    input  xpos, ypos, state_out, airborne, landed
  );

  modport slave (
    input  v_tick, btn_jump, btn_left, btn_right,
    output xpos, ypos, state_out, airborne, landed
  );
endinterface

// File: rtl/sprite_jump_ctl.sv
// Frame-rate sprite motion controller: jump with rise, apex hold and
// gravity fall, plus clamped left/right movement, updated on v_tick rising edges.
//
// state | meaning
// IDLE  | on the ground, waiting for a jump press
// RISE  | moving up by RISE_STEP per frame toward the apex
// HOLD  | parked at the apex for HOLD_FRAMES frames
// FALL  | falling with velocity growing by GRAVITY up to VMAX
// LAND  | touched down; waits for the jump button to be released
module sprite_jump_ctl #(
  parameter int X_INIT      = 350,
  parameter int Y_GROUND    = 400,
  parameter int JUMP_HEIGHT = 100,
  parameter int RISE_STEP   = 4,
  parameter int HOLD_FRAMES = 3,
  parameter int GRAVITY     = 1,
  parameter int VMAX        = 8,
  parameter int X_STEP      = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 700
) (
  input logic               clk,
  input logic               rst,
  sprite_jump_ctl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RISE = 3'd1,
    HOLD = 3'd2,
    FALL = 3'd3,
    LAND = 3'd4
  } state_t;

  localparam logic [11:0] X_INIT12   = 12'(X_INIT);
  localparam logic [11:0] GROUND12   = 12'(Y_GROUND);
  localparam logic [11:0] APEX12     = 12'(Y_GROUND - JUMP_HEIGHT);
  localparam logic [11:0] RISE12     = 12'(RISE_STEP);
  localparam logic [12:0] GROUND13   = 13'(Y_GROUND);
  localparam logic [12:0] APEX13     = 13'(Y_GROUND - JUMP_HEIGHT);
  localparam logic [12:0] RISE13     = 13'(RISE_STEP);
  localparam logic [7:0]  HOLD8      = 8'(HOLD_FRAMES);
  localparam logic [4:0]  GRAV5      = 5'(GRAVITY);
  localparam logic [4:0]  VMAX5      = 5'(VMAX);
  localparam logic signed [12:0] XSTEP_S = 13'(X_STEP);
  localparam logic signed [12:0] XMIN_S  = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);

  state_t      state, state_nxt;
  logic [11:0] xpos_q, x_nxt;
  logic [11:0] ypos_q, y_nxt;
  logic [4:0]  vel, vel_nxt;
  logic [7:0]  hold_cnt, cnt_nxt, cnt_inc;
  logic        v_tick_q;
  logic        landed_q;
  logic        land_evt;
  logic        frame;

  logic [12:0] y_sum;
  logic [5:0]  vel_sum;
  logic signed [12:0] x_dec, x_inc;

  assign frame   = bus.v_tick & ~v_tick_q;
  assign cnt_inc = hold_cnt + 8'd1;
  assign y_sum   = {1'b0, ypos_q} + {8'd0, vel};
  assign vel_sum = {1'b0, vel} + {1'b0, GRAV5};
  assign x_dec   = $signed({1'b0, xpos_q}) - XSTEP_S;
  assign x_inc   = $signed({1'b0, xpos_q}) + XSTEP_S;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      xpos_q   <= X_INIT12;
      ypos_q   <= GROUND12;
      vel      <= '0;
      hold_cnt <= '0;
      v_tick_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      v_tick_q <= bus.v_tick;
      landed_q <= frame & land_evt;
      if (frame) begin
        state    <= state_nxt;
        xpos_q   <= x_nxt;
        ypos_q   <= y_nxt;
        vel      <= vel_nxt;
        hold_cnt <= cnt_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = ypos_q;
    vel_nxt   = vel;
    cnt_nxt   = hold_cnt;
    land_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.btn_jump) state_nxt = RISE;
      end
      RISE: begin
        if (!bus.btn_jump) begin
          state_nxt = FALL;
          vel_nxt   = GRAV5;
        end else if ({1'b0, ypos_q} > APEX13 + RISE13) begin
          // Equivalent to ypos - RISE_STEP > apex, without underflow
          y_nxt = ypos_q - RISE12;
        end else begin
          y_nxt   = APEX12;
          cnt_nxt = '0;
          if (HOLD8 == 8'd0) begin
            state_nxt = FALL;
            vel_nxt   = GRAV5;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == HOLD8) begin
          state_nxt = FALL;
          vel_nxt   = GRAV5;
        end
      end
      FALL: begin
        if (y_sum >= GROUND13) begin
          y_nxt     = GROUND12;
          vel_nxt   = '0;
          state_nxt = LAND;
          land_evt  = 1'b1;
        end else begin
          y_nxt   = y_sum[11:0];
          vel_nxt = (vel_sum > {1'b0, VMAX5}) ? VMAX5 : vel_sum[4:0];
        end
      end
      LAND: begin
        if (!bus.btn_jump) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_nxt = xpos_q;
    if (bus.btn_left && !bus.btn_right)
      x_nxt = (x_dec < XMIN_S) ? XMIN_S[11:0] : x_dec[11:0];
    else if (bus.btn_right && !bus.btn_left)
      x_nxt = (x_inc > XMAX_S) ? XMAX_S[11:0] : x_inc[11:0];
  end

  assign bus.xpos      = xpos_q;
  assign bus.ypos      = ypos_q;
  assign bus.state_out = state;
  assign bus.airborne  = (state == RISE) || (state == HOLD) || (state == FALL);
  assign bus.landed    = landed_q;

endmodule

// File: tb/tb_sprite_jump_ctl.sv
// Directed bench for sprite_jump_ctl: per-frame vector table plus
// hand-written sequences for v_tick edge detection and mid-fall reset.
module tb_sprite_jump_ctl;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RISE = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
  localparam logic [2:0] S_LAND = 3'd4;

  typedef struct {
    logic        j;
    logic        l;
    logic        r;
    logic [2:0]  st;
    logic [11:0] x;
    logic [11:0] y;
    logic        air;
    logic        lnd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_jump_ctl_if bus();
  sprite_jump_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   land_cycles = 0;
  int   mx = 350;

  always @(negedge clk) if (bus.landed === 1'b1) land_cycles++;

  // Expected x follows the clamp rule on a running copy; y/state are hand values.
  function automatic void add(input logic j, input logic l, input logic r,
                              input logic [2:0] st, input int y, input logic lnd);
    vec_t v;
    if (l && !r) mx = (mx - 2 < 0) ? 0 : mx - 2;
    else if (r && !l) mx = (mx + 2 > 700) ? 700 : mx + 2;
    v.j = j; v.l = l; v.r = r;
    v.st  = st;
    v.x   = 12'(mx);
    v.y   = 12'(y);
    v.air = (st == S_RISE) || (st == S_HOLD) || (st == S_FALL);
    v.lnd = lnd;
    vecs.push_back(v);
  endfunction

  task automatic frame(input logic j, input logic l, input logic r);
    @(negedge clk);
    bus.btn_jump  = j;
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.v_tick    = 1'b1;
    @(negedge clk);
    bus.v_tick    = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int fl1[15] = '{301, 303, 306, 310, 315, 321, 328, 336, 344, 352, 360, 368, 376, 384, 392};
    int fl3[5]  = '{381, 383, 386, 390, 395};

    // full jump, button held throughout
    add(1, 0, 0, S_RISE, 400, 0);
    for (int k = 1; k <= 24; k++) add(1, 0, 0, S_RISE, 400 - 4 * k, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, S_HOLD, 300, 0);
    add(1, 0, 0, S_FALL, 300, 0);
    for (int k = 0; k < 15; k++) add(1, 0, 0, S_FALL, fl1[k], 0);
    add(1, 0, 0, S_LAND, 400, 1);
    add(1, 0, 0, S_LAND, 400, 0);
    add(1, 0, 0, S_LAND, 400, 0);
    add(0, 0, 0, S_IDLE, 400, 0);
    add(0, 0, 0, S_IDLE, 400, 0);
    // early release while moving right
    add(1, 0, 1, S_RISE, 400, 0);
    for (int k = 1; k <= 5; k++) add(1, 0, 1, S_RISE, 400 - 4 * k, 0);
    add(0, 0, 1, S_FALL, 380, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, S_FALL, fl3[k], 0);
    add(0, 0, 1, S_LAND, 400, 1);
    add(0, 0, 1, S_IDLE, 400, 0);
    // horizontal saturation
    for (int k = 0; k < 200; k++) add(0, 0, 1, S_IDLE, 400, 0);
    for (int k = 0; k < 3; k++)   add(0, 1, 1, S_IDLE, 400, 0);
    for (int k = 0; k < 400; k++) add(0, 1, 0, S_IDLE, 400, 0);

    rst = 1'b1;
    bus.v_tick = 1'b0; bus.btn_jump = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", int'(bus.state_out), 0);
    chk("reset_x", int'(bus.xpos), 350);
    chk("reset_y", int'(bus.ypos), 400);
    chk("reset_air_landed", int'({bus.airborne, bus.landed}), 0);

    foreach (vecs[i]) begin
      frame(vecs[i].j, vecs[i].l, vecs[i].r);
      tests++;
      if ({bus.state_out, bus.xpos, bus.ypos, bus.airborne, bus.landed} !==
          {vecs[i].st, vecs[i].x, vecs[i].y, vecs[i].air, vecs[i].lnd}) begin
        fails++;
        $display("FAIL vec%0d: got st=%0d x=%0d y=%0d air=%0d lnd=%0d expected st=%0d x=%0d y=%0d air=%0d lnd=%0d",
                 i, bus.state_out, bus.xpos, bus.ypos, bus.airborne, bus.landed,
                 vecs[i].st, vecs[i].x, vecs[i].y, vecs[i].air, vecs[i].lnd);
      end
    end
    chk("landed_pulse_cycles", land_cycles, 2);

    // v_tick held high: one update only; then 1-on/1-off toggling
    frame(1, 0, 0);
    chk("t5_start_y", int'(bus.ypos), 400);
    @(negedge clk);
    bus.v_tick = 1'b1;
    repeat (50) @(negedge clk);
    bus.v_tick = 1'b0;
    @(negedge clk);
    chk("t5_level_held_y", int'(bus.ypos), 396);
    chk("t5_level_held_state", int'(bus.state_out), int'(S_RISE));
    repeat (4) begin
      @(negedge clk);
      bus.v_tick = 1'b1;
      @(negedge clk);
      bus.v_tick = 1'b0;
    end
    @(negedge clk);
    chk("t5_toggle_y", int'(bus.ypos), 380);

    // reset during FALL at y=340
    repeat (10) frame(1, 0, 0);
    chk("t6_rise_y", int'(bus.ypos), 340);
    frame(0, 0, 0);
    chk("t6_fall_state", int'(bus.state_out), int'(S_FALL));
    chk("t6_fall_y", int'(bus.ypos), 340);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_state", int'(bus.state_out), int'(S_IDLE));
    chk("t6_rst_y", int'(bus.ypos), 400);
    chk("t6_rst_x", int'(bus.xpos), 350);
    chk("t6_rst_air", int'(bus.airborne), 0);
    repeat (20) frame(0, 0, 0);
    chk("t6_after_y", int'(bus.ypos), 400);
    chk("t6_after_state", int'(bus.state_out), int'(S_IDLE));
    chk("t6_no_landed", land_cycles, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
